uart_bus_master: RTL and testbench

//  Serial-to-bus bridge: receives 8N1 command frames on a UART line and acts as bus

---
 rtl/uart_bus_master.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART debug/loader bridge: 8N1 command frames in, one bus initiator cycle
// (CYC/STB/WE/SEL/ACK) out, status/data reply frames back over TX.
module uart_bus_master #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 1250,
    parameter int TIMEOUT      = 1024
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_RX,
    output logic                  o_TX,
    output logic [ADDR_WIDTH-1:0] o_ADDR,
    output logic [DATA_WIDTH-1:0] o_DATA,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    output logic                  o_WE,
    output logic [3:0]            o_SEL,
    output logic                  o_STB,
    output logic                  o_CYC,
    input  logic                  i_ACK,
    output logic                  o_BUSY
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0] CMD_W = 8'h57, CMD_R = 8'h52, RSP_K = 8'h4B;
    localparam logic [7:0] RSP_D = 8'h44, RSP_Q = 8'h3F, RSP_E = 8'h45;

    typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    state_t r_state, w_state_n;

    logic          r_rx_meta, r_rx_sync, r_rx_prev, r_rx_busy, r_rx_valid, r_rx_ferr;
    logic [CW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;

    logic          r_tx_out, r_tx_busy;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;
    logic [8:0]    r_tx_shift;
    logic          w_tx_end, w_tx_ready, w_tx_go, w_tx_load;
    logic [7:0]    w_tx_byte, w_resp_byte;
    logic [2:0]    w_resp_len;

    logic                  r_is_write, r_cyc, r_we, r_err, r_q_pend, r_busy;
    logic [1:0]            r_cnt;
    logic [2:0]            r_resp_idx;
    logic [3:0]            r_sel;
    logic [TW-1:0]         r_to_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_sh, r_addr;
    logic [DATA_WIDTH-1:0] r_data_sh, r_wdata, r_rdata;

    // RX: synchroniser, start validation at half bit, mid-bit sampling, stop check
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_cnt   <= {CW{1'b0}};
            r_rx_bit   <= 4'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_meta  <= i_RX;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            if (!r_rx_busy) begin
                if (r_rx_prev && !r_rx_sync) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= {CW{1'b0}};
                    r_rx_bit  <= 4'd0;
                end
            end else if (r_rx_bit == 4'd0) begin
                if (r_rx_cnt == HALF_LAST) begin
                    r_rx_cnt <= {CW{1'b0}};
                    if (r_rx_sync) r_rx_busy <= 1'b0;
                    else           r_rx_bit  <= 4'd1;
                end else begin
                    r_rx_cnt <= r_rx_cnt + 1'b1;
                end
            end else if (r_rx_cnt == BIT_LAST) begin
                r_rx_cnt <= {CW{1'b0}};
                if (r_rx_bit == 4'd9) begin
                    r_rx_busy  <= 1'b0;
                    r_rx_valid <= r_rx_sync;
                    r_rx_ferr  <= !r_rx_sync;
                end else begin
                    r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 4'd1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
        end
    end

    // A new byte may be loaded on the last cycle of a stop bit, so bytes run back-to-back
    assign w_tx_end   = r_tx_busy && (r_tx_bit == 4'd9) && (r_tx_cnt == BIT_LAST);
    assign w_tx_ready = !r_tx_busy || w_tx_end;
    assign w_tx_go    = w_tx_load && w_tx_ready;

    // TX: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_tx_out   <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_cnt   <= {CW{1'b0}};
            r_tx_bit   <= 4'd0;
            r_tx_shift <= 9'h1FF;
        end else if (w_tx_go) begin
            r_tx_out   <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_cnt   <= {CW{1'b0}};
            r_tx_bit   <= 4'd0;
            r_tx_shift <= {1'b1, w_tx_byte};
        end else if (r_tx_busy) begin
            if (r_tx_cnt == BIT_LAST) begin
                r_tx_cnt <= {CW{1'b0}};
                if (r_tx_bit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                end else begin
                    r_tx_out   <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                    r_tx_bit   <= r_tx_bit + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    assign w_resp_len = (r_err || r_is_write) ? 3'd1 : 3'd5;

    // Reply byte selection
    always_comb begin
        w_resp_byte = 8'h00;
        case (r_resp_idx)
            3'd0:    w_resp_byte = r_err ? RSP_E : (r_is_write ? RSP_K : RSP_D);
            3'd1:    w_resp_byte = r_rdata[31:24];
            3'd2:    w_resp_byte = r_rdata[23:16];
            3'd3:    w_resp_byte = r_rdata[15:8];
            3'd4:    w_resp_byte = r_rdata[7:0];
            default: w_resp_byte = 8'h00;
        endcase
    end

    // Frame parser state register
    always_ff @(posedge i_CLK) begin
        if (i_RST) r_state <= S_CMD;
        else       r_state <= w_state_n;
    end

    // Frame parser next state and TX byte request
    always_comb begin
        w_state_n = r_state;
        w_tx_load = 1'b0;
        w_tx_byte = 8'h00;
        case (r_state)
            S_CMD: begin
                if (r_rx_valid && (r_rx_shift == CMD_W || r_rx_shift == CMD_R)) w_state_n = S_ADDR;
                else w_state_n = S_CMD;
            end
            S_ADDR: begin
                if (r_rx_ferr) w_state_n = S_CMD;
                else if (r_rx_valid && r_cnt == 2'd3) w_state_n = r_is_write ? S_DATA : S_BUS;
                else w_state_n = S_ADDR;
            end
            S_DATA: begin
                if (r_rx_ferr) w_state_n = S_CMD;
                else if (r_rx_valid && r_cnt == 2'd3) w_state_n = S_BUS;
                else w_state_n = S_DATA;
            end
            S_BUS: begin
                if ((r_cyc && i_ACK) || r_to_cnt == TO_LAST) w_state_n = S_RESP;
                else w_state_n = S_BUS;
            end
            S_RESP: begin
                if (r_resp_idx == w_resp_len && w_tx_end) w_state_n = S_CMD;
                else w_state_n = S_RESP;
            end
            default: w_state_n = S_CMD;
        endcase
        if (r_state == S_RESP) begin
            if (r_resp_idx != w_resp_len) begin
                w_tx_load = 1'b1;
                w_tx_byte = w_resp_byte;
            end else begin
                w_tx_load = 1'b0;
            end
        end else if (r_q_pend) begin
            w_tx_load = 1'b1;
            w_tx_byte = RSP_Q;
        end else begin
            w_tx_load = 1'b0;
        end
    end

    // Field assembly, bus handshake, ack timeout and reply sequencing
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_is_write <= 1'b0;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_q_pend   <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= 2'd0;
            r_resp_idx <= 3'd0;
            r_sel      <= 4'h0;
            r_to_cnt   <= {TW{1'b0}};
            r_addr_sh  <= {ADDR_WIDTH{1'b0}};
            r_addr     <= {ADDR_WIDTH{1'b0}};
            r_data_sh  <= {DATA_WIDTH{1'b0}};
            r_wdata    <= {DATA_WIDTH{1'b0}};
            r_rdata    <= {DATA_WIDTH{1'b0}};
        end else begin
            r_busy <= (r_state != S_CMD) || r_tx_busy || r_q_pend || (r_rx_valid && r_state == S_CMD);
            if (w_tx_go && r_state != S_RESP) r_q_pend <= 1'b0;
            case (r_state)
                S_CMD: begin
                    if (r_rx_valid) begin
                        r_is_write <= (r_rx_shift == CMD_W);
                        r_cnt      <= 2'd0;
                        if (w_state_n == S_CMD) r_q_pend <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (r_rx_valid) begin
                        r_addr_sh <= {r_addr_sh[ADDR_WIDTH-9:0], r_rx_shift};
                        r_cnt     <= r_cnt + 2'd1;
                    end
                end
                S_DATA: begin
                    if (r_rx_valid) begin
                        r_data_sh <= {r_data_sh[DATA_WIDTH-9:0], r_rx_shift};
                        r_cnt     <= r_cnt + 2'd1;
                    end
                end
                S_BUS: begin
                    if (r_cyc && i_ACK) begin
                        r_rdata    <= i_DATA;
                        r_cyc      <= 1'b0;
                        r_sel      <= 4'h0;
                        r_we       <= 1'b0;
                        r_resp_idx <= 3'd0;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_cyc      <= 1'b0;
                        r_sel      <= 4'h0;
                        r_we       <= 1'b0;
                        r_err      <= 1'b1;
                        r_resp_idx <= 3'd0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_tx_go) r_resp_idx <= r_resp_idx + 3'd1;
                end
                default: ;
            endcase
            // The final frame byte is still in the RX shifter, so splice it in directly
            if (w_state_n == S_BUS && r_state != S_BUS) begin
                r_cyc    <= 1'b1;
                r_sel    <= 4'hF;
                r_we     <= r_is_write;
                r_err    <= 1'b0;
                r_to_cnt <= {TW{1'b0}};
                if (r_is_write) begin
                    r_addr  <= r_addr_sh;
                    r_wdata <= {r_data_sh[DATA_WIDTH-9:0], r_rx_shift};
                end else begin
                    r_addr  <= {r_addr_sh[ADDR_WIDTH-9:0], r_rx_shift};
                end
            end
        end
    end

    assign o_TX   = r_tx_out;
    assign o_ADDR = r_addr;
    assign o_DATA = r_wdata;
    assign o_WE   = r_we;
    assign o_SEL  = r_sel;
    assign o_STB  = r_cyc;
    assign o_CYC  = r_cyc;
    assign o_BUSY = r_busy;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: UART frames in, scoreboarded bus cycles
// and reply bytes checked by a bus responder and a TX decoder.
module tb_uart_bus_master;
    localparam int CPB = 16;
    localparam int TO  = 32;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          ack_dly;
        logic [31:0] rdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        i_RST, i_RX, i_ACK;
    logic [31:0] i_DATA;
    logic        o_TX, o_WE, o_STB, o_CYC, o_BUSY;
    logic [31:0] o_ADDR, o_DATA;
    logic [3:0]  o_SEL;

    int total = 0;
    int bad = 0;
    int rst_cnt = 0;
    logic [7:0] txq[$];
    bus_t       busq[$];

    uart_bus_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CLKS_PER_BIT(CPB), .TIMEOUT(TO)) dut (
        .i_CLK(clk), .i_RST(i_RST), .i_RX(i_RX), .o_TX(o_TX),
        .o_ADDR(o_ADDR), .o_DATA(o_DATA), .i_DATA(i_DATA), .o_WE(o_WE),
        .o_SEL(o_SEL), .o_STB(o_STB), .o_CYC(o_CYC), .i_ACK(i_ACK), .o_BUSY(o_BUSY)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (i_RST) rst_cnt <= rst_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        i_RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_RX = b[i];
            repeat (CPB) @(negedge clk);
        end
        i_RX = stop;
        repeat (CPB) @(negedge clk);
        i_RX = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
    endtask

    task automatic push_bus(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input int dly, input logic [31:0] rd);
        bus_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.ack_dly = dly; e.rdata = rd;
        busq.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_BUSY === 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_fall"}, {63'd0, o_BUSY}, 64'd0);
        repeat (20) @(negedge clk);
        chk({tag, "_tx_left"}, txq.size(), 64'd0);
        chk({tag, "_bus_left"}, busq.size(), 64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        i_RST = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_cyc"}, {63'd0, o_CYC}, 64'd0);
        chk({tag, "_stb"}, {63'd0, o_STB}, 64'd0);
        chk({tag, "_tx"}, {63'd0, o_TX}, 64'd1);
        chk({tag, "_busy"}, {63'd0, o_BUSY}, 64'd0);
        @(negedge clk);
        i_RST = 1'b0;
    endtask

    // TX decoder: samples each bit mid-cell and scores bytes against txq
    initial begin
        logic [7:0] b;
        logic st, sp;
        int r0;
        forever begin
            @(negedge o_TX);
            r0 = rst_cnt;
            repeat (CPB / 2) @(posedge clk);
            #1 st = o_TX;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 b[i] = o_TX;
            end
            repeat (CPB) @(posedge clk);
            #1 sp = o_TX;
            if (rst_cnt == r0 && !i_RST) begin
                chk("tx_start_bit", {63'd0, st}, 64'd0);
                chk("tx_stop_bit", {63'd0, sp}, 64'd1);
                total++;
                assert (txq.size() != 0) else begin
                    bad++;
                    $error("FAIL tx_unexpected: got %02h expected none", b);
                end
                if (txq.size() != 0) chk("tx_byte", {56'd0, b}, {56'd0, txq.pop_front()});
            end
        end
    end

    // Bus responder: checks each cycle against busq, then ACKs or lets it time out
    initial begin
        bus_t e;
        int n, r0;
        i_ACK  = 1'b0;
        i_DATA = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!i_RST && o_CYC === 1'b1) begin
                r0 = rst_cnt;
                e.addr = 32'h0; e.we = 1'b0; e.wdata = 32'h0; e.ack_dly = 1; e.rdata = 32'h0;
                total++;
                assert (busq.size() != 0) else begin
                    bad++;
                    $error("FAIL bus_unexpected: got addr %08h expected no cycle", o_ADDR);
                end
                if (busq.size() != 0) e = busq.pop_front();
                chk("bus_addr", {32'd0, o_ADDR}, {32'd0, e.addr});
                chk("bus_we", {63'd0, o_WE}, {63'd0, e.we});
                chk("bus_sel", {60'd0, o_SEL}, 64'hF);
                chk("bus_stb", {63'd0, o_STB}, 64'd1);
                if (e.we) chk("bus_wdata", {32'd0, o_DATA}, {32'd0, e.wdata});
                if (e.ack_dly < 0) begin
                    n = 0;
                    while (o_STB === 1'b1 && n < 200) begin
                        n++;
                        @(posedge clk);
                        #1;
                    end
                    if (rst_cnt == r0) chk("bus_timeout_len", n, TO);
                end else begin
                    repeat (e.ack_dly) @(posedge clk);
                    #1;
                    chk("bus_addr_hold", {32'd0, o_ADDR}, {32'd0, e.addr});
                    chk("bus_stb_hold", {63'd0, o_STB}, 64'd1);
                    i_ACK  = 1'b1;
                    i_DATA = e.rdata;
                    @(posedge clk);
                    #1;
                    i_ACK  = 1'b0;
                    i_DATA = 32'h0;
                    chk("bus_cyc_drop", {63'd0, o_CYC}, 64'd0);
                end
            end
        end
    end

    initial begin
        i_RST = 1'b1;
        i_RX  = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_tx", {63'd0, o_TX}, 64'd1);
        chk("rst_cyc", {63'd0, o_CYC}, 64'd0);
        chk("rst_stb", {63'd0, o_STB}, 64'd0);
        chk("rst_we", {63'd0, o_WE}, 64'd0);
        chk("rst_sel", {60'd0, o_SEL}, 64'd0);
        chk("rst_addr", {32'd0, o_ADDR}, 64'd0);
        chk("rst_data", {32'd0, o_DATA}, 64'd0);
        chk("rst_busy", {63'd0, o_BUSY}, 64'd0);
        i_RST = 1'b0;
        repeat (5) @(negedge clk);

        // 1: write, ACK after 3 cycles
        push_bus(32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 3, 32'h0);
        txq.push_back(8'h4B);
        send_byte(8'h57, 1'b1);
        chk("t1_busy_rise", {63'd0, o_BUSY}, 64'd1);
        send_word(32'h0000_1000);
        send_word(32'hDEAD_BEEF);
        wait_idle("t1");
        chk("t1_addr_kept", {32'd0, o_ADDR}, 64'h1000);
        chk("t1_data_kept", {32'd0, o_DATA}, 64'hDEAD_BEEF);

        // 2: read returning 0x41
        push_bus(32'h0000_0004, 1'b0, 32'h0, 2, 32'h0000_0041);
        txq.push_back(8'h44); txq.push_back(8'h00); txq.push_back(8'h00);
        txq.push_back(8'h00); txq.push_back(8'h41);
        send_byte(8'h52, 1'b1);
        send_word(32'h0000_0004);
        wait_idle("t2");
        chk("t2_data_kept", {32'd0, o_DATA}, 64'hDEAD_BEEF);

        // 3: read with no ACK times out, then a read with immediate ACK
        push_bus(32'h0000_0008, 1'b0, 32'h0, -1, 32'h0);
        txq.push_back(8'h45);
        send_byte(8'h52, 1'b1);
        send_word(32'h0000_0008);
        wait_idle("t3a");
        push_bus(32'h0000_000C, 1'b0, 32'h0, 0, 32'hCAFE_F00D);
        txq.push_back(8'h44); txq.push_back(8'hCA); txq.push_back(8'hFE);
        txq.push_back(8'hF0); txq.push_back(8'h0D);
        send_byte(8'h52, 1'b1);
        send_word(32'h0000_000C);
        wait_idle("t3b");

        // 4: unknown command, then a short low glitch
        txq.push_back(8'h3F);
        send_byte(8'h13, 1'b1);
        wait_idle("t4a");
        @(negedge clk);
        i_RX = 1'b0;
        repeat (4) @(negedge clk);
        i_RX = 1'b1;
        repeat (300) @(negedge clk);
        chk("t4_glitch_busy", {63'd0, o_BUSY}, 64'd0);
        wait_idle("t4b");

        // 5: framing error inside a write frame, then a valid write
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b0);
        repeat (50) @(negedge clk);
        chk("t5_ferr_busy", {63'd0, o_BUSY}, 64'd0);
        repeat (300) @(negedge clk);
        wait_idle("t5a");
        push_bus(32'h0000_2000, 1'b1, 32'h0102_0304, 2, 32'h0);
        txq.push_back(8'h4B);
        send_byte(8'h57, 1'b1);
        send_word(32'h0000_2000);
        send_word(32'h0102_0304);
        wait_idle("t5b");

        // 6: reset during a bus cycle, then during a reply byte, then recovery
        push_bus(32'h0000_0020, 1'b0, 32'h0, -1, 32'h0);
        send_byte(8'h52, 1'b1);
        send_word(32'h0000_0020);
        for (int n = 0; n < 100 && o_CYC !== 1'b1; n++) @(negedge clk);
        chk("t6_cyc_seen", {63'd0, o_CYC}, 64'd1);
        repeat (5) @(negedge clk);
        pulse_reset("t6_rst_bus");
        send_byte(8'h13, 1'b1);
        for (int n = 0; n < 400 && o_TX !== 1'b0; n++) @(negedge clk);
        chk("t6_tx_started", {63'd0, o_TX}, 64'd0);
        repeat (40) @(negedge clk);
        pulse_reset("t6_rst_tx");
        repeat (200) @(negedge clk);
        chk("t6_tx_idle", {63'd0, o_TX}, 64'd1);
        push_bus(32'h0000_0030, 1'b0, 32'h0, 1, 32'h1234_5678);
        txq.push_back(8'h44); txq.push_back(8'h12); txq.push_back(8'h34);
        txq.push_back(8'h56); txq.push_back(8'h78);
        send_byte(8'h52, 1'b1);
        send_word(32'h0000_0030);
        wait_idle("t6c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
